// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS tap presets and LFSR step/word/lock-up helper functions
package prbs_pkg;

    localparam int          PRBS7_ORDER  = 7;
    localparam logic [31:0] PRBS7_TAPS   = 32'h0000_0003;
    localparam bit          PRBS7_XNOR   = 1'b0;
    localparam int          PRBS9_ORDER  = 9;
    localparam logic [31:0] PRBS9_TAPS   = 32'h0000_0011;
    localparam bit          PRBS9_XNOR   = 1'b1;
    localparam int          PRBS15_ORDER = 15;
    localparam logic [31:0] PRBS15_TAPS  = 32'h0000_0003;
    localparam bit          PRBS15_XNOR  = 1'b0;
    localparam int          PRBS23_ORDER = 23;
    localparam logic [31:0] PRBS23_TAPS  = 32'h0000_0021;
    localparam bit          PRBS23_XNOR  = 1'b0;
    localparam int          PRBS31_ORDER = 31;
    localparam logic [31:0] PRBS31_TAPS  = 32'h0000_0009;
    localparam bit          PRBS31_XNOR  = 1'b0;

    // XNOR feedback sticks at all-ones, XOR feedback sticks at all-zeros.
    function automatic logic [31:0] lockup_value(input int order, input bit fb_xnor);
        logic [31:0] v;
        v = '0;
        if (fb_xnor) begin
            for (int i = 0; i < 32; i++) begin
                if (i < order) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int order,
                                              input logic [31:0] taps, input bit fb_xnor);
        logic        fb;
        logic [31:0] n;
        fb = ^(s & taps);
        if (fb_xnor) fb = ~fb;
        n = s >> 1;
        for (int i = 0; i < 32; i++) begin
            if (i == order - 1) n[i] = fb;
        end
        return n;
    endfunction

    function automatic logic [31:0] lfsr_word(input logic [31:0] s, input int order,
                                              input logic [31:0] taps, input bit fb_xnor,
                                              input int nbits);
        logic [31:0] st;
        logic [31:0] w;
        st = s;
        w  = '0;
        for (int k = 0; k < 32; k++) begin
            if (k < nbits) begin
                w[k] = st[0];
                st   = lfsr_step(st, order, taps, fb_xnor);
            end
        end
        return w;
    endfunction

    function automatic logic [31:0] lfsr_advance(input logic [31:0] s, input int order,
                                                 input logic [31:0] taps, input bit fb_xnor,
                                                 input int nsteps);
        logic [31:0] st;
        st = s;
        for (int k = 0; k < 32; k++) begin
            if (k < nsteps) st = lfsr_step(st, order, taps, fb_xnor);
        end
        return st;
    endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// rtl/prbs_lfsr_core.sv - one PRBS channel: state, NBITS-step unroll, word, lock-up check
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter int               ORDER   = 9,
    parameter logic [ORDER-1:0] TAPS    = 9'h011,
    parameter bit               FB_XNOR = 1'b1,
    parameter int               NBITS   = 1,
    parameter logic [ORDER-1:0] SEED    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic [ORDER-1:0] i_seed,
    output logic [NBITS-1:0] o_word,
    output logic             o_at_seed,
    output logic             o_lockup
);

    localparam logic [ORDER-1:0] LOCKUP = ORDER'(lockup_value(ORDER, FB_XNOR));

    logic [ORDER-1:0] state_q, state_d;
    logic [ORDER-1:0] act_seed_q, act_seed_d;
    logic [ORDER-1:0] load_seed;

    always_comb begin
        o_lockup   = (i_seed == LOCKUP);
        load_seed  = o_lockup ? SEED : i_seed;
        state_d    = state_q;
        act_seed_d = act_seed_q;
        if (i_load) begin
            state_d    = load_seed;
            act_seed_d = load_seed;
        end else if (i_adv) begin
            state_d = ORDER'(lfsr_advance(32'(state_q), ORDER, 32'(TAPS), FB_XNOR, NBITS));
        end
    end

    assign o_word    = NBITS'(lfsr_word(32'(state_q), ORDER, 32'(TAPS), FB_XNOR, NBITS));
    assign o_at_seed = (state_q == act_seed_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEED;
            act_seed_q <= SEED;
        end else begin
            state_q    <= state_d;
            act_seed_q <= act_seed_d;
        end
    end

endmodule

// File: rtl/prbs_gen_mc.sv
// rtl/prbs_gen_mc.sv - multi-channel parallel PRBS generator with valid/ready output
// Optional PRBS_ERR_INJ_EN adds i_err_inj (flips bit 0 of every channel's captured word).
module prbs_gen_mc
    import prbs_pkg::*;
#(
    parameter int                   ORDER   = 9,
    parameter logic [ORDER-1:0]     TAPS    = 9'h011,
    parameter bit                   FB_XNOR = 1'b1,
    parameter int                   NBITS   = 1,
    parameter int                   NCH     = 2,
    parameter logic [NCH*ORDER-1:0] SEEDS   = {9'h0AA, 9'h000}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_load,
    input  logic [NCH*ORDER-1:0] i_seed,
    input  logic                 i_ready,
`ifdef PRBS_ERR_INJ_EN
    input  logic                 i_err_inj,
`endif
    output logic [NCH*NBITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_wrap,
    output logic                 o_lockup_err
);

    logic                 adv;
    logic [NCH*NBITS-1:0] word_all;
    logic [NCH*NBITS-1:0] inj_mask;
    logic [NCH-1:0]       at_seed;
    logic [NCH-1:0]       lockup_vec;
    logic                 unused_at_seed;

    logic [NCH*NBITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic                 lockup_err_q, lockup_err_d;

    assign adv = i_enable & (~valid_q | i_ready);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        prbs_lfsr_core #(
            .ORDER   (ORDER),
            .TAPS    (TAPS),
            .FB_XNOR (FB_XNOR),
            .NBITS   (NBITS),
            .SEED    (SEEDS[c*ORDER +: ORDER])
        ) u_core (
            .clk       (clk),
            .rst       (rst),
            .i_load    (i_load),
            .i_adv     (adv),
            .i_seed    (i_seed[c*ORDER +: ORDER]),
            .o_word    (word_all[c*NBITS +: NBITS]),
            .o_at_seed (at_seed[c]),
            .o_lockup  (lockup_vec[c])
        );
    end

    // Only channel 0 defines the period marker.
    assign unused_at_seed = ^at_seed;

    always_comb begin
        inj_mask = '0;
`ifdef PRBS_ERR_INJ_EN
        for (int c = 0; c < NCH; c++) begin
            inj_mask[c*NBITS] = i_err_inj;
        end
`endif
    end

    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        wrap_d       = wrap_q;
        lockup_err_d = 1'b0;
        if (i_load) begin
            valid_d      = 1'b0;
            wrap_d       = 1'b0;
            lockup_err_d = |lockup_vec;
        end else if (adv) begin
            data_d  = word_all ^ inj_mask;
            valid_d = 1'b1;
            wrap_d  = at_seed[0];
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            wrap_q       <= 1'b0;
            lockup_err_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            valid_q      <= valid_d;
            wrap_q       <= wrap_d;
            lockup_err_q <= lockup_err_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_wrap       = wrap_q;
    assign o_lockup_err = lockup_err_q;

endmodule

// File: tb/tb_prbs_gen_mc.sv
// tb/tb_prbs_gen_mc.sv - randomized self-checking bench for prbs_gen_mc (NBITS=1 and NBITS=8)
module tb_prbs_gen_mc;

    localparam int         GLEN  = 16384;
    localparam logic [8:0] SEED0 = 9'h000;
    localparam logic [8:0] SEED1 = 9'h0AA;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        en   = 1'b0;
    logic        load = 1'b0;
    logic        rdy1 = 1'b0;
    logic        rdy8 = 1'b0;
    logic [17:0] seed = '0;
`ifdef PRBS_ERR_INJ_EN
    logic        err_inj = 1'b0;
`endif

    logic [1:0]  data1;
    logic        valid1, wrap1, lerr1;
    logic [15:0] data8;
    logic        valid8, wrap8, lerr8;

    int checks = 0;
    int errors = 0;
    bit g0[GLEN];
    bit g1[GLEN];
    int acc1, acc8, inj_word, wrap8_seen;

    always #5 clk = ~clk;

    prbs_gen_mc #(.NBITS(1)) dut1 (
        .clk(clk), .rst(rst), .i_enable(en), .i_load(load), .i_seed(seed), .i_ready(rdy1),
`ifdef PRBS_ERR_INJ_EN
        .i_err_inj(err_inj),
`endif
        .o_data(data1), .o_valid(valid1), .o_wrap(wrap1), .o_lockup_err(lerr1)
    );

    prbs_gen_mc #(.NBITS(8)) dut8 (
        .clk(clk), .rst(rst), .i_enable(en), .i_load(load), .i_seed(seed), .i_ready(rdy8),
`ifdef PRBS_ERR_INJ_EN
        .i_err_inj(err_inj),
`endif
        .o_data(data8), .o_valid(valid8), .o_wrap(wrap8), .o_lockup_err(lerr8)
    );

    // Golden bit streams: a(n) = seed bit n for n<9, then a(n) = ~(a(n-9) ^ a(n-5)).
    task automatic model_init(input logic [8:0] s0, input logic [8:0] s1);
        for (int n = 0; n < GLEN; n++) begin
            if (n < 9) begin
                g0[n] = s0[n];
                g1[n] = s1[n];
            end else begin
                g0[n] = ~(g0[n-9] ^ g0[n-5]);
                g1[n] = ~(g1[n-9] ^ g1[n-5]);
            end
        end
        acc1 = 0;
        acc8 = 0;
        inj_word = -1;
        wrap8_seen = 0;
    endtask

    // Scoreboard: every word accepted downstream is the next slice of the golden stream.
    always @(negedge clk) begin : mon
        logic [1:0]  e1;
        logic [15:0] e8;
        logic        ew;
        if (valid1 && rdy1) begin
            e1 = {g1[acc1], g0[acc1]};
            if (acc1 == inj_word) e1 = ~e1;
            ew = ((acc1 % 511) == 0);
            checks++;
            if (data1 !== e1) begin
                errors++;
                $display("FAIL sb_data1 word %0d: got %b expected %b", acc1, data1, e1);
            end
            checks++;
            if (wrap1 !== ew) begin
                errors++;
                $display("FAIL sb_wrap1 word %0d: got %b expected %b", acc1, wrap1, ew);
            end
            acc1++;
        end
        if (valid8 && rdy8) begin
            for (int k = 0; k < 8; k++) begin
                e8[k]   = g0[acc8*8 + k];
                e8[8+k] = g1[acc8*8 + k];
            end
            if (acc8 == inj_word) e8 = e8 ^ 16'h0101;
            ew = (((acc8 * 8) % 511) == 0);
            if (wrap8) wrap8_seen++;
            checks++;
            if (data8 !== e8) begin
                errors++;
                $display("FAIL sb_data8 word %0d: got %h expected %h", acc8, data8, e8);
            end
            checks++;
            if (wrap8 !== ew) begin
                errors++;
                $display("FAIL sb_wrap8 word %0d: got %b expected %b", acc8, wrap8, ew);
            end
            acc8++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        rdy1 = 1'b0;
        rdy8 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        model_init(SEED0, SEED1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({valid1, wrap1, lerr1, data1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_dut1: got v=%b w=%b e=%b d=%b expected all 0", valid1, wrap1, lerr1, data1);
        end
        checks++;
        if ({valid8, wrap8, lerr8, data8} !== 19'b0) begin
            errors++;
            $display("FAIL reset_dut8: got v=%b w=%b e=%b d=%h expected all 0", valid8, wrap8, lerr8, data8);
        end
        rst = 1'b1;
        model_init(SEED0, SEED1);
        tick();
        checks++;
        if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b expected 0", valid1);
        end
    endtask

    task automatic test_sequence();
        logic [9:0] first_bits;
        logic       ch1_first;
        int         n;
        int         wrap_idx[$];
        do_reset();
        en = 1'b1;
        rdy1 = 1'b1;
        rdy8 = 1'b1;
        n = 0;
        first_bits = '0;
        ch1_first = 1'b1;
        for (int i = 0; i < 530; i++) begin
            @(negedge clk);
            if (valid1) begin
                if (n < 10) first_bits[n] = data1[0];
                if (n == 0) ch1_first = data1[1];
                if (wrap1) wrap_idx.push_back(n);
                n++;
            end
        end
        tick();
        checks++;
        if (first_bits !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL seq_first10: got %b expected 1000000000", first_bits);
        end
        checks++;
        if (ch1_first !== 1'b0) begin
            errors++;
            $display("FAIL seq_ch1_first: got %b expected 0", ch1_first);
        end
        checks++;
        if (wrap_idx.size() != 2 || wrap_idx[0] != 0 || wrap_idx[1] != 511) begin
            errors++;
            $display("FAIL seq_wrap_period: got %0d wraps first=%0d second=%0d expected 2 at 0,511",
                     wrap_idx.size(), (wrap_idx.size() > 0) ? wrap_idx[0] : -1,
                     (wrap_idx.size() > 1) ? wrap_idx[1] : -1);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        en = 1'b1;
        rdy1 = 1'b1;
        cyc = 0;
        while (cyc < 3000 && acc8 < 520) begin
            rdy8 = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        rdy8 = 1'b0;
        tick();
        checks++;
        if (acc8 < 520) begin
            errors++;
            $display("FAIL bp_timeout: got %0d words expected 520", acc8);
        end
        checks++;
        if (wrap8_seen != 2) begin
            errors++;
            $display("FAIL bp_wrap_count: got %0d expected 2", wrap8_seen);
        end
    endtask

    task automatic test_load_lockup();
        do_reset();
        en = 1'b1;
        rdy1 = 1'b1;
        rdy8 = 1'b1;
        repeat (30) tick();
        load = 1'b1;
        seed = {9'h1FF, 9'h155};
        tick();
        load = 1'b0;
        model_init(9'h155, SEED1);
        checks++;
        if ({valid1, lerr1, valid8, lerr8} !== 4'b0101) begin
            errors++;
            $display("FAIL load_edge: got v1=%b e1=%b v8=%b e8=%b expected v=0 e=1",
                     valid1, lerr1, valid8, lerr8);
        end
        tick();
        checks++;
        if ({valid1, lerr1} !== 2'b10) begin
            errors++;
            $display("FAIL load_after: got v=%b e=%b expected v=1 e=0", valid1, lerr1);
        end
        checks++;
        if ({wrap1, data1} !== {1'b1, g1[0], g0[0]}) begin
            errors++;
            $display("FAIL load_first_word: got w=%b d=%b expected w=1 d=%b%b", wrap1, data1, g1[0], g0[0]);
        end
        repeat (40) tick();
    endtask

    task automatic test_load_adv();
        logic [8:0] s0, s1;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            en = 1'b1;
            rdy1 = 1'b1;
            repeat ($urandom_range(10, 30)) begin
                rdy8 = 1'($urandom_range(0, 1));
                tick();
            end
            s0 = 9'($urandom_range(0, 510));
            s1 = 9'($urandom_range(0, 510));
            rdy8 = 1'b1;
            load = 1'b1;
            seed = {s1, s0};
            tick();
            load = 1'b0;
            model_init(s0, s1);
            checks++;
            if ({valid1, valid8, lerr1} !== 3'b000) begin
                errors++;
                $display("FAIL ldadv_edge %0d: got v1=%b v8=%b e=%b expected 0", r, valid1, valid8, lerr1);
            end
            tick();
            checks++;
            if ({valid1, data1} !== {1'b1, g1[0], g0[0]}) begin
                errors++;
                $display("FAIL ldadv_first %0d: got v=%b d=%b expected v=1 d=%b%b", r, valid1, data1, g1[0], g0[0]);
            end
            repeat (30) begin
                rdy8 = 1'($urandom_range(0, 1));
                tick();
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [1:0]  d1;
        logic [15:0] d8;
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        d1 = data1;
        d8 = data8;
        repeat (20) begin
            tick();
            checks++;
            if ({valid1, valid8, data1, data8} !== {2'b11, d1, d8}) begin
                errors++;
                $display("FAIL hold: got v1=%b v8=%b d1=%b d8=%h expected v=1 d1=%b d8=%h",
                         valid1, valid8, data1, data8, d1, d8);
            end
        end
        en = 1'b1;
        rdy1 = 1'b1;
        rdy8 = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        tick();
        tick();
        checks++;
        if ({valid1, valid8} !== 2'b00) begin
            errors++;
            $display("FAIL drain: got v1=%b v8=%b expected 0", valid1, valid8);
        end
    endtask

`ifdef PRBS_ERR_INJ_EN
    task automatic test_err_inj();
        do_reset();
        en = 1'b1;
        rdy1 = 1'b1;
        rdy8 = 1'b1;
        inj_word = 100;
        for (int i = 0; i < 120; i++) begin
            err_inj = (i == 100);
            tick();
            if (i == 100) begin
                checks++;
                if (data1 !== {~g1[100], ~g0[100]}) begin
                    errors++;
                    $display("FAIL inj_word100: got %b expected %b%b", data1, ~g1[100], ~g0[100]);
                end
            end
        end
        err_inj = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        rdy1 = 1'b1;
        rdy8 = 1'b1;
        repeat (25) tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({valid1, wrap1, data1, valid8, data8} !== 20'b0) begin
            errors++;
            $display("FAIL mid_reset: got v1=%b w1=%b d1=%b v8=%b d8=%h expected 0",
                     valid1, wrap1, data1, valid8, data8);
        end
        tick();
        rst = 1'b1;
        model_init(SEED0, SEED1);
        tick();
        checks++;
        if ({valid1, wrap1, data1} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_restart: got v=%b w=%b d=%b expected v=1 w=1 d=00", valid1, wrap1, data1);
        end
        repeat (20) tick();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_backpressure();
        test_load_lockup();
        test_load_adv();
        test_enable_hold();
`ifdef PRBS_ERR_INJ_EN
        test_err_inj();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
